qgate_unit: RTL

Parametrised single-qubit gate engine: applies a selectable real 2×2 unitary (I, X, Z, H, or caller-supplied coefficients) to one amplitude pair (up = |0>, down = |1>) held in signed fixed point. It generalises the float Hadamard root block and keeps the same go/running/done handshake, so the path-integral datapath can swap it in per qubit. One shared multiplier is time-multiplexed over the four products, giving a fixed 5-cycle latency.

---
 rtl/qgate_pkg.sv | 28 ++
 rtl/qgate_mac.sv | 66 ++++++
 rtl/qgate_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/qgate_pkg.sv
// Shared encodings and constants for the single-qubit gate engine.
package qgate_pkg;

    localparam logic [2:0] SEL_I      = 3'd0;
    localparam logic [2:0] SEL_X      = 3'd1;
    localparam logic [2:0] SEL_Z      = 3'd2;
    localparam logic [2:0] SEL_H      = 3'd3;
    localparam logic [2:0] SEL_CUSTOM = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MU0  = 3'd1,
        ST_MU1  = 3'd2,
        ST_MD0  = 3'd3,
        ST_MD1  = 3'd4,
        ST_FIN  = 3'd5
    } qgate_state_e;

    localparam logic [63:0] INV_SQRT2_Q62 = 64'h2D41_3CCC_FE77_9921;

    // 1/sqrt(2) rounded half-up from Q62 down to 'frac' fraction bits (frac <= 61).
    function automatic logic [63:0] inv_sqrt2_q(input int frac);
        logic [64:0] t;
        t = {1'b0, INV_SQRT2_Q62} + (65'(1) << (61 - frac));
        return 64'(t >> (62 - frac));
    endfunction

endpackage

// File: rtl/qgate_mac.sv
// Shared multiplier and accumulator with round-half-up rescale to WIDTH bits.
// QGATE_SAT_EN defined: out-of-range results clamp; otherwise they wrap.
module qgate_mac
    import qgate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 30
) (
    input  logic                    clk,
    input  logic                    lowrst,
    input  logic                    acc_clr,
    input  logic                    acc_add,
    input  logic signed [WIDTH-1:0] mul_a,
    input  logic signed [WIDTH-1:0] mul_b,
    output logic signed [WIDTH-1:0] res,
    output logic                    ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = 2 * WIDTH + 1;
    localparam int SW = 2 * WIDTH + 2;
    localparam logic signed [SW-1:0] RND_C = ((SW)'(1) << FRAC) >> 1;
    localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] shifted;

    assign prod     = $signed({{WIDTH{mul_a[WIDTH-1]}}, mul_a}) * $signed({{WIDTH{mul_b[WIDTH-1]}}, mul_b});
    assign prod_ext = {prod[PW-1], prod};

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = prod_ext;
        end else if (acc_add) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!lowrst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Extra top bit keeps the rounding add from ever overflowing.
    assign rnd     = {acc_q[AW-1], acc_q} + RND_C;
    assign shifted = rnd >>> FRAC;
    assign ovf     = (shifted[SW-1:WIDTH-1] != {(SW-WIDTH+1){shifted[WIDTH-1]}});

    always_comb begin
        res = shifted[WIDTH-1:0];
`ifdef QGATE_SAT_EN
        if (ovf) begin
            res = shifted[SW-1] ? MIN_V : MAX_V;
        end
`endif
    end

endmodule

// File: rtl/qgate_unit.sv
// Single-qubit real 2x2 gate engine, fixed 5-cycle latency, go/running/done handshake.
// Overflow handling selected by QGATE_SAT_EN (clamp) vs default (wrap), inside qgate_mac.
//
// state | meaning
// IDLE  | waiting for gate_go
// MU0   | acc = m00*up
// MU1   | acc += m01*down
// MD0   | capture up result, acc = m10*up
// MD1   | acc += m11*down
// FIN   | publish outputs, pulse done; may accept the next go
module qgate_unit
    import qgate_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 30
) (
    input  logic                    clk,
    input  logic                    lowrst,
    input  logic                    gate_go,
    input  logic [2:0]              gate_sel,
    input  logic signed [WIDTH-1:0] gate_up,
    input  logic signed [WIDTH-1:0] gate_down,
    input  logic [4*WIDTH-1:0]      gate_coef,
    output logic signed [WIDTH-1:0] gate_upout,
    output logic signed [WIDTH-1:0] gate_downout,
    output logic                    gate_running,
    output logic                    gate_done,
    output logic                    gate_ovf,
    output logic                    gate_err
);

    localparam logic [63:0] C64 = inv_sqrt2_q(FRAC);
    localparam logic signed [WIDTH-1:0] C_H   = WIDTH'(C64);
    localparam logic signed [WIDTH-1:0] C_ONE = (WIDTH)'(1) << FRAC;

    qgate_state_e state_q, state_d;
    logic signed [WIDTH-1:0] up_q, up_d, dn_q, dn_d;
    logic signed [WIDTH-1:0] m00_q, m00_d, m01_q, m01_d, m10_q, m10_d, m11_q, m11_d;
    logic                    sel_err_q, sel_err_d;
    logic signed [WIDTH-1:0] upres_q, upres_d;
    logic                    upovf_q, upovf_d;
    logic signed [WIDTH-1:0] upout_q, upout_d, downout_q, downout_d;
    logic                    running_q, running_d, done_q, done_d;
    logic                    ovf_q, ovf_d, err_q, err_d;

    logic                    accept;
    logic                    acc_clr, acc_add;
    logic signed [WIDTH-1:0] mul_a, mul_b;
    logic signed [WIDTH-1:0] mac_res;
    logic                    mac_ovf;

    qgate_mac #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mac (
        .clk     (clk),
        .lowrst  (lowrst),
        .acc_clr (acc_clr),
        .acc_add (acc_add),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .res     (mac_res),
        .ovf     (mac_ovf)
    );

    always_comb begin
        state_d   = state_q;
        up_d      = up_q;
        dn_d      = dn_q;
        m00_d     = m00_q;
        m01_d     = m01_q;
        m10_d     = m10_q;
        m11_d     = m11_q;
        sel_err_d = sel_err_q;
        upres_d   = upres_q;
        upovf_d   = upovf_q;
        upout_d   = upout_q;
        downout_d = downout_q;
        running_d = running_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        err_d     = err_q;
        accept    = 1'b0;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        mul_a     = m00_q;
        mul_b     = up_q;

        case (state_q)
            ST_IDLE: accept = gate_go;
            ST_MU0: begin
                acc_clr = 1'b1;
                state_d = ST_MU1;
            end
            ST_MU1: begin
                mul_a   = m01_q;
                mul_b   = dn_q;
                acc_add = 1'b1;
                state_d = ST_MD0;
            end
            ST_MD0: begin
                mul_a   = m10_q;
                acc_clr = 1'b1;
                upres_d = mac_res;
                upovf_d = mac_ovf;
                state_d = ST_MD1;
            end
            ST_MD1: begin
                mul_a   = m11_q;
                mul_b   = dn_q;
                acc_add = 1'b1;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                upout_d   = upres_q;
                downout_d = mac_res;
                ovf_d     = upovf_q | mac_ovf;
                err_d     = sel_err_q;
                done_d    = 1'b1;
                running_d = 1'b0;
                state_d   = ST_IDLE;
                // Taking go here gives one op every 5 cycles back to back.
                accept    = gate_go;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            up_d      = gate_up;
            dn_d      = gate_down;
            sel_err_d = (gate_sel > SEL_CUSTOM);
            running_d = 1'b1;
            state_d   = ST_MU0;
            case (gate_sel)
                SEL_X: begin
                    m00_d = '0;    m01_d = C_ONE; m10_d = C_ONE; m11_d = '0;
                end
                SEL_Z: begin
                    m00_d = C_ONE; m01_d = '0;    m10_d = '0;    m11_d = -C_ONE;
                end
                SEL_H: begin
                    m00_d = C_H;   m01_d = C_H;   m10_d = C_H;   m11_d = -C_H;
                end
                SEL_CUSTOM: begin
                    m00_d = gate_coef[4*WIDTH-1:3*WIDTH];
                    m01_d = gate_coef[3*WIDTH-1:2*WIDTH];
                    m10_d = gate_coef[2*WIDTH-1:WIDTH];
                    m11_d = gate_coef[WIDTH-1:0];
                end
                default: begin
                    m00_d = C_ONE; m01_d = '0;    m10_d = '0;    m11_d = C_ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!lowrst) begin
            state_q   <= ST_IDLE;
            up_q      <= '0;
            dn_q      <= '0;
            m00_q     <= '0;
            m01_q     <= '0;
            m10_q     <= '0;
            m11_q     <= '0;
            sel_err_q <= 1'b0;
            upres_q   <= '0;
            upovf_q   <= 1'b0;
            upout_q   <= '0;
            downout_q <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            m00_q     <= m00_d;
            m01_q     <= m01_d;
            m10_q     <= m10_d;
            m11_q     <= m11_d;
            sel_err_q <= sel_err_d;
            upres_q   <= upres_d;
            upovf_q   <= upovf_d;
            upout_q   <= upout_d;
            downout_q <= downout_d;
            running_q <= running_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    assign gate_upout   = upout_q;
    assign gate_downout = downout_q;
    assign gate_running = running_q;
    assign gate_done    = done_q;
    assign gate_ovf     = ovf_q;
    assign gate_err     = err_q;

endmodule
